// File: rtl/controle_multiciclo.sv
// Multicycle control unit for a small RISC-V datapath (lw, sw, sub, xor, addi, srl, beq).
// Optional cycle/retired-instruction counters are enabled with CONTROLE_CONTADORES_EN.
module controle_multiciclo #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  estado,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        regwrite,
    output logic        alusrc,
    output logic [1:0]  aluop,
    output logic [3:0]  alucontrol,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        branch,
    output logic        done,
    output logic        erro,
    output logic [31:0] ciclos,
    output logic [31:0] instrucoes
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EX  = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100,
        S_FIM = 3'b110
    } estado_t;

    typedef enum logic [2:0] {
        C_NONE, C_LW, C_SW, C_ADDI, C_SUB, C_XOR, C_SRL, C_BEQ
    } classe_t;

    localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

    estado_t    estado_q, estado_d;
    classe_t    classe_q, classe_d, classe_dec;
    logic       done_q, done_d;
    logic       erro_q, erro_d;
    logic [7:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= S_FIM;
            classe_q <= C_NONE;
            done_q   <= 1'b0;
            erro_q   <= 1'b0;
            tmo_q    <= 8'd0;
        end else begin
            estado_q <= estado_d;
            classe_q <= classe_d;
            done_q   <= done_d;
            erro_q   <= erro_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        classe_dec = C_NONE;
        case (opcode)
            7'b0000011: if (funct3 == 3'b010) classe_dec = C_LW;
            7'b0100011: if (funct3 == 3'b010) classe_dec = C_SW;
            7'b0010011: if (funct3 == 3'b000) classe_dec = C_ADDI;
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0100000)      classe_dec = C_SUB;
                else if (funct3 == 3'b100 && funct7 == 7'b0000000) classe_dec = C_XOR;
                else if (funct3 == 3'b101 && funct7 == 7'b0000000) classe_dec = C_SRL;
            end
            7'b1100011: if (funct3 == 3'b000) classe_dec = C_BEQ;
            default: classe_dec = C_NONE;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        classe_d   = classe_q;
        done_d     = done_q;
        erro_d     = erro_q;
        tmo_d      = tmo_q;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        regwrite   = 1'b0;
        alusrc     = 1'b0;
        aluop      = 2'b00;
        alucontrol = 4'b0000;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        branch     = 1'b0;
        case (estado_q)
            S_FIM: begin
                if (start) begin
                    done_d   = 1'b0;
                    erro_d   = 1'b0;
                    estado_d = S_IF;
                end
            end
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                estado_d = S_ID;
            end
            S_ID: begin
                classe_d = classe_dec;
                if (opcode == 7'b0000000) begin
                    done_d   = 1'b1;
                    erro_d   = 1'b0;
                    estado_d = S_FIM;
                end else if (classe_dec == C_NONE) begin
                    done_d   = 1'b0;
                    erro_d   = 1'b1;
                    estado_d = S_FIM;
                end else begin
                    estado_d = S_EX;
                end
            end
            S_EX: begin
                case (classe_q)
                    C_LW, C_SW, C_ADDI: begin
                        alusrc     = 1'b1;
                        alucontrol = 4'b0010;
                        tmo_d      = 8'd0;
                        estado_d   = (classe_q == C_ADDI) ? S_WB : S_MEM;
                    end
                    C_SUB, C_XOR, C_SRL: begin
                        aluop      = 2'b10;
                        alucontrol = (classe_q == C_SUB) ? 4'b0110 :
                                     (classe_q == C_XOR) ? 4'b0011 : 4'b0101;
                        estado_d   = S_WB;
                    end
                    C_BEQ: begin
                        aluop      = 2'b01;
                        alucontrol = 4'b0110;
                        branch     = 1'b1;
                        pc_src     = 1'b1;
                        pc_write   = zero;
                        estado_d   = S_IF;
                    end
                    default: begin
                        erro_d   = 1'b1;
                        done_d   = 1'b0;
                        estado_d = S_FIM;
                    end
                endcase
            end
            S_MEM: begin
                memread  = (classe_q == C_LW);
                memwrite = (classe_q == C_SW);
                if (mem_ready) begin
                    estado_d = (classe_q == C_LW) ? S_WB : S_IF;
                end else if (tmo_q + 8'd1 == TMO_LIM) begin
                    // abort: the access never completed within the budget
                    erro_d   = 1'b1;
                    done_d   = 1'b0;
                    estado_d = S_FIM;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = (classe_q == C_LW);
                estado_d = S_IF;
            end
            default: begin
                erro_d   = 1'b1;
                done_d   = 1'b0;
                estado_d = S_FIM;
            end
        endcase
    end

    assign estado = estado_q;
    assign done   = done_q;
    assign erro   = erro_q;

`ifdef CONTROLE_CONTADORES_EN
    logic [31:0] ciclos_q, ciclos_d;
    logic [31:0] instr_q, instr_d;
    logic        retire;

    assign retire = (estado_q == S_EX && classe_q == C_BEQ) ||
                    (estado_q == S_MEM && classe_q == C_SW && mem_ready) ||
                    (estado_q == S_WB);

    always_comb begin
        ciclos_d = ciclos_q;
        instr_d  = instr_q;
        if (estado_q == S_FIM) begin
            if (start) begin
                ciclos_d = 32'd0;
                instr_d  = 32'd0;
            end
        end else begin
            ciclos_d = ciclos_q + 32'd1;
            if (retire) instr_d = instr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ciclos_q <= 32'd0;
            instr_q  <= 32'd0;
        end else begin
            ciclos_q <= ciclos_d;
            instr_q  <= instr_d;
        end
    end

    assign ciclos     = ciclos_q;
    assign instrucoes = instr_q;
`else
    assign ciclos     = 32'd0;
    assign instrucoes = 32'd0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Table-driven bench for controle_multiciclo: per-cycle vectors of inputs and expected
// Moore outputs, plus hand sequences for counters and reset during a memory access.
module tb_controle_multiciclo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  estado;
    logic        pc_write, pc_src, ir_write, regwrite, alusrc;
    logic [1:0]  aluop;
    logic [3:0]  alucontrol;
    logic        memread, memwrite, memtoreg, branch, done, erro;
    logic [31:0] ciclos, instrucoes;

    always #5 clk = ~clk;

    controle_multiciclo #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
        .estado(estado), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .regwrite(regwrite), .alusrc(alusrc), .aluop(aluop), .alucontrol(alucontrol),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .branch(branch),
        .done(done), .erro(erro), .ciclos(ciclos), .instrucoes(instrucoes)
    );

    // {estado, pcw pcs irw rw, alusrc, aluop, alucontrol, mr mw mtr br, done erro}
    localparam logic [19:0] O_FIM      = 20'b110_0000_0_00_0000_0000_00;
    localparam logic [19:0] O_FIM_DONE = 20'b110_0000_0_00_0000_0000_10;
    localparam logic [19:0] O_FIM_ERR  = 20'b110_0000_0_00_0000_0000_01;
    localparam logic [19:0] O_IF       = 20'b000_1010_0_00_0000_0000_00;
    localparam logic [19:0] O_ID       = 20'b001_0000_0_00_0000_0000_00;
    localparam logic [19:0] O_EX_IMM   = 20'b010_0000_1_00_0010_0000_00;
    localparam logic [19:0] O_EX_SUB   = 20'b010_0000_0_10_0110_0000_00;
    localparam logic [19:0] O_EX_XOR   = 20'b010_0000_0_10_0011_0000_00;
    localparam logic [19:0] O_EX_SRL   = 20'b010_0000_0_10_0101_0000_00;
    localparam logic [19:0] O_EX_BEQ1  = 20'b010_1100_0_01_0110_0001_00;
    localparam logic [19:0] O_EX_BEQ0  = 20'b010_0100_0_01_0110_0001_00;
    localparam logic [19:0] O_MEM_LW   = 20'b011_0000_0_00_0000_1000_00;
    localparam logic [19:0] O_MEM_SW   = 20'b011_0000_0_00_0000_0100_00;
    localparam logic [19:0] O_WB_LW    = 20'b100_0001_0_00_0000_0010_00;
    localparam logic [19:0] O_WB_ALU   = 20'b100_0001_0_00_0000_0000_00;

    typedef struct {
        string       name;
        logic        start;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        mr;
        logic [19:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [6:0]  ir_op;
    logic [2:0]  ir_f3;
    logic [6:0]  ir_f7;
    int          nvec = 0;
    int          nerr = 0;
    logic [19:0] obs;

    assign obs = {estado, pc_write, pc_src, ir_write, regwrite, alusrc, aluop, alucontrol,
                  memread, memwrite, memtoreg, branch, done, erro};

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        ir_op = op; ir_f3 = f3; ir_f7 = f7;
    endtask

    task automatic add(input string n, input logic s, input logic z, input logic mr,
                       input logic [19:0] e);
        vec_t v;
        v.name = n; v.start = s; v.op = ir_op; v.f3 = ir_f3; v.f7 = ir_f7;
        v.z = z; v.mr = mr; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string n, input logic [19:0] e);
        nvec++;
        if (obs !== e) begin
            nerr++;
            $display("FAIL %s: outputs %b, required %b", n, obs, e);
        end
    endtask

    task automatic check32(input string n, input logic [31:0] got, input logic [31:0] e);
        nvec++;
        if (got !== e) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", n, got, e);
        end
    endtask

    // Called at posedge+1: drive, settle, compare, then advance one cycle.
    task automatic apply(input vec_t v);
        start = v.start; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
        zero = v.z; mem_ready = v.mr;
        #1;
        check(v.name, v.exp);
        @(posedge clk); #1;
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_R  = 7'b0110011, OP_BR = 7'b1100011;

    logic [31:0] exp_cic, exp_ins;

    initial begin
        do_reset();
        check("reset_state", O_FIM);
        check32("reset_ciclos", ciclos, 32'd0);

        // addi, start ignored while in ID, mem_ready ignored outside MEM
        set_ir(OP_IMM, 3'b000, 7'b0);
        add("fim_start", 1, 0, 0, O_FIM);
        add("addi_if", 0, 0, 0, O_IF);
        add("addi_id", 1, 0, 1, O_ID);
        add("addi_ex", 0, 0, 1, O_EX_IMM);
        add("addi_wb", 0, 0, 0, O_WB_ALU);
        set_ir(OP_R, 3'b000, 7'b0100000);
        add("sub_if", 0, 0, 0, O_IF);
        add("sub_id", 0, 0, 0, O_ID);
        add("sub_ex", 0, 0, 0, O_EX_SUB);
        add("sub_wb", 0, 0, 0, O_WB_ALU);
        set_ir(OP_R, 3'b100, 7'b0);
        add("xor_if", 0, 0, 0, O_IF);
        add("xor_id", 0, 0, 0, O_ID);
        add("xor_ex", 0, 0, 0, O_EX_XOR);
        add("xor_wb", 0, 0, 0, O_WB_ALU);
        set_ir(OP_R, 3'b101, 7'b0);
        add("srl_if", 0, 0, 0, O_IF);
        add("srl_id", 0, 0, 0, O_ID);
        add("srl_ex", 0, 0, 0, O_EX_SRL);
        add("srl_wb", 0, 0, 0, O_WB_ALU);
        set_ir(OP_BR, 3'b000, 7'b0);
        add("beq1_if", 0, 1, 0, O_IF);
        add("beq1_id", 0, 1, 0, O_ID);
        add("beq1_ex", 0, 1, 0, O_EX_BEQ1);
        add("beq0_if", 0, 0, 0, O_IF);
        add("beq0_id", 0, 0, 0, O_ID);
        add("beq0_ex", 0, 0, 0, O_EX_BEQ0);
        set_ir(OP_LW, 3'b010, 7'b0);
        add("lw_if", 0, 0, 0, O_IF);
        add("lw_id", 0, 0, 0, O_ID);
        add("lw_ex", 0, 0, 0, O_EX_IMM);
        add("lw_mem1", 0, 0, 0, O_MEM_LW);
        add("lw_mem2", 0, 0, 0, O_MEM_LW);
        add("lw_mem3", 1, 0, 0, O_MEM_LW);
        add("lw_mem4", 0, 0, 1, O_MEM_LW);
        add("lw_wb", 0, 0, 0, O_WB_LW);
        set_ir(OP_SW, 3'b010, 7'b0);
        add("sw_if", 0, 0, 0, O_IF);
        add("sw_id", 0, 0, 0, O_ID);
        add("sw_ex", 0, 0, 0, O_EX_IMM);
        add("sw_mem", 0, 0, 1, O_MEM_SW);
        // sub opcode with a bad funct7 is illegal
        set_ir(OP_R, 3'b000, 7'b0000001);
        add("ill_if", 0, 0, 0, O_IF);
        add("ill_id", 0, 0, 0, O_ID);
        add("ill_fim", 0, 0, 0, O_FIM_ERR);
        add("ill_start", 1, 0, 0, O_FIM_ERR);
        set_ir(7'b0, 3'b0, 7'b0);
        add("halt_if", 0, 0, 0, O_IF);
        add("halt_id", 0, 0, 0, O_ID);
        add("halt_fim", 0, 0, 0, O_FIM_DONE);
        add("halt_hold", 0, 0, 0, O_FIM_DONE);
        add("halt_start", 1, 0, 0, O_FIM_DONE);
        set_ir(OP_SW, 3'b010, 7'b0);
        add("tmo_if", 0, 0, 0, O_IF);
        add("tmo_id", 0, 0, 0, O_ID);
        add("tmo_ex", 0, 0, 0, O_EX_IMM);
        for (int k = 0; k < 15; k++) add($sformatf("tmo_mem%0d", k + 1), 0, 0, 0, O_MEM_SW);
        add("tmo_fim", 0, 0, 0, O_FIM_ERR);
        add("tmo_start", 1, 0, 0, O_FIM_ERR);
        add("tmo_restart", 0, 0, 0, O_IF);
        run_tbl();

        // counters across one lw with three stalled MEM cycles
        do_reset();
        set_ir(OP_LW, 3'b010, 7'b0);
        add("cnt_start", 1, 0, 0, O_FIM);
        add("cnt_if", 0, 0, 0, O_IF);
        add("cnt_id", 0, 0, 0, O_ID);
        add("cnt_ex", 0, 0, 0, O_EX_IMM);
        for (int k = 0; k < 3; k++) add("cnt_mem_wait", 0, 0, 0, O_MEM_LW);
        add("cnt_mem_rdy", 0, 0, 1, O_MEM_LW);
        add("cnt_wb", 0, 0, 0, O_WB_LW);
        run_tbl();
        mem_ready = 1'b0; #1;
        check("cnt_back_if", O_IF);
`ifdef CONTROLE_CONTADORES_EN
        exp_cic = 32'd8; exp_ins = 32'd1;
`else
        exp_cic = 32'd0; exp_ins = 32'd0;
`endif
        check32("ciclos_lw", ciclos, exp_cic);
        check32("instrucoes_lw", instrucoes, exp_ins);
        @(posedge clk); #1;

        // reset asserted in the middle of a store
        do_reset();
        set_ir(OP_SW, 3'b010, 7'b0);
        add("rst_start", 1, 0, 0, O_FIM);
        add("rst_if", 0, 0, 0, O_IF);
        add("rst_id", 0, 0, 0, O_ID);
        add("rst_ex", 0, 0, 0, O_EX_IMM);
        add("rst_mem1", 0, 0, 0, O_MEM_SW);
        run_tbl();
        #1;
        check("rst_mem2", O_MEM_SW);
        reset_n = 1'b0;
        #1;
        check("rst_mid_mem", O_FIM);
        check32("rst_ciclos", ciclos, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_hold", O_FIM);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
